// File: rtl/loba_div_pkg.sv
// Shared definitions for the leading-one based approximate divider.
// Holds the default operand width N, the leading-one segment width K, the
// number of restoring-division iterations and the controller state encoding.
package loba_div_pkg;

  localparam int N          = 16;
  localparam int K          = 4;
  localparam int DIV_CYCLES = 3 * K;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPLIT,
    S_DIV,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/loba_div_lod.sv
// loba_lod: combinational leading-one detector and segment extractor.
// Ports:
//   val_i  [N-1:0]  operand
//   pos_o  [KW-1:0] index of the most significant set bit (0 when val_i==0)
//   seg_o  [K-1:0]  the K bits from pos_o downward, zero-filled below bit 0
module loba_lod #(
  parameter int N  = loba_div_pkg::N,
  parameter int K  = loba_div_pkg::K,
  localparam int KW = $clog2(N)
) (
  input  logic [N-1:0]  val_i,
  output logic [KW-1:0] pos_o,
  output logic [K-1:0]  seg_o
);

  localparam int EW = N + K - 1;

  // Operand shifted up by K-1 so a segment that runs past bit 0 picks up zeros.
  logic [EW-1:0] ext;

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < N; i++) begin
      if (val_i[i]) pos_o = KW'(i);
    end
  end

  assign ext   = EW'(val_i) << (K - 1);
  assign seg_o = ext[pos_o +: K];

endmodule

// File: rtl/loba_div_16_4.sv
// loba_div_16_4: approximate unsigned divider. Each operand is reduced to its
// leading-one position and a K-bit segment; the segments are divided by a
// 3K-step restoring divider and the quotient is re-scaled by the position
// difference.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid / in_ready, a, b   operand handshake (in_ready only in IDLE)
//   out_valid / out_ready, q, dz  result handshake, held until accepted
// Build option: define LOBA_DIV_ROUND_EN to round right-shifted quotients to
// nearest (saturating); otherwise they are truncated. Latency is identical.
module loba_div_16_4 #(
  parameter int N = loba_div_pkg::N,
  parameter int K = loba_div_pkg::K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         dz
);

  import loba_div_pkg::*;

  localparam int QW = 3 * K;          // quotient / dividend width
  localparam int KW = $clog2(N);      // leading-one position width
  localparam int CW = $clog2(QW);     // iteration counter width
  localparam int SW = KW + 3;         // signed shift width

  state_e state_q, state_d;

  logic [N-1:0]  a_q, b_q;
  logic [KW-1:0] ka_q, kb_q;
  logic [QW-1:0] dvd_q;               // dividend shifting out, quotient shifting in
  logic [K-1:0]  rem_q;
  logic [K-1:0]  bh_q;
  logic [CW-1:0] cnt_q;
  logic          zwait_q;             // special-result path holds SPLIT one extra cycle
  logic [N-1:0]  q_q;
  logic          dz_q;

  logic [KW-1:0] ka_w, kb_w;
  logic [K-1:0]  ah_w, bh_w;
  logic          zero_op;

  loba_lod #(.N(N), .K(K)) u_lod_a (.val_i(a_q), .pos_o(ka_w), .seg_o(ah_w));
  loba_lod #(.N(N), .K(K)) u_lod_b (.val_i(b_q), .pos_o(kb_w), .seg_o(bh_w));

  assign zero_op = (a_q == '0) || (b_q == '0);

  // One restoring-division step.
  logic [K:0]    trial;
  logic          ge;
  logic [K-1:0]  diff, rem_d;
  logic [QW-1:0] dvd_d;

  assign trial = {rem_q, dvd_q[QW-1]};
  assign ge    = trial >= {1'b0, bh_q};
  assign diff  = K'(trial - {1'b0, bh_q});
  assign rem_d = ge ? diff : trial[K-1:0];
  assign dvd_d = {dvd_q[QW-2:0], ge};

  // Re-scaling: s = ka - kb - 2K, left shift when s >= 0, right shift otherwise.
  logic [SW-1:0] s_w, s_mag;
  logic          s_neg;
  logic [N-1:0]  q_left, q_right, q_norm;
`ifdef LOBA_DIV_ROUND_EN
  logic [QW:0]   rwide;
  logic [N:0]    rsum;
`endif

  always_comb begin
    s_w    = SW'(ka_q) - SW'(kb_q) - SW'(2 * K);
    s_neg  = s_w[SW-1];
    s_mag  = s_neg ? (~s_w + SW'(1)) : s_w;
    q_left = N'({{N{1'b0}}, dvd_q} << s_mag);
`ifdef LOBA_DIV_ROUND_EN
    // Carry one guard bit through the shift; it is the highest bit dropped.
    rwide   = {dvd_q, 1'b0} >> s_mag;
    rsum    = (N + 1)'(rwide[QW:1]) + (N + 1)'(rwide[0]);
    q_right = rsum[N] ? '1 : rsum[N-1:0];
`else
    q_right = N'(dvd_q >> s_mag);
`endif
    q_norm = s_neg ? q_right : q_left;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SPLIT;
      S_SPLIT: begin
        if (!zero_op)     state_d = S_DIV;
        else if (zwait_q) state_d = S_DONE;
      end
      S_DIV:   if (cnt_q == CW'(QW - 1)) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is reset, not just the visible q/dz, so an
    // abandoned division leaves nothing behind that the next one could see.
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      bh_q    <= '0;
      cnt_q   <= '0;
      zwait_q <= 1'b0;
      q_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          zwait_q <= 1'b0;
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        S_SPLIT: begin
          ka_q    <= ka_w;
          kb_q    <= kb_w;
          dvd_q   <= {ah_w, {(2 * K){1'b0}}};
          bh_q    <= bh_w;
          rem_q   <= '0;
          cnt_q   <= '0;
          zwait_q <= 1'b1;
          if (zero_op && zwait_q) begin
            q_q  <= (b_q == '0) ? '1 : '0;
            dz_q <= (b_q == '0);
          end
        end
        S_DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
        end
        S_NORM: begin
          q_q  <= q_norm;
          dz_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign q  = q_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_loba_div_16_4.sv
// Directed self-checking bench for loba_div_16_4 (hand-computed vectors).
module tb_loba_div_16_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        dz;

  int n_pass   = 0;
  int n_checks = 0;

`ifdef LOBA_DIV_ROUND_EN
  localparam logic [15:0] Q_100_10 = 16'd10;
`else
  localparam logic [15:0] Q_100_10 = 16'd9;
`endif

  always #5 clk = ~clk;

  loba_div_16_4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .dz       (dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Waits (bounded) for out_valid; returns the number of edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called #1 after an edge with the DUT idle. Accepts on the next edge (e0).
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_q, input logic exp_dz, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_dz"}, 32'(dz), 32'(exp_dz));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_q",         32'(q),         32'd0);
    check("reset_dz",        32'(dz),        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ka=6 Ah=12, kb=3 Bh=10, qm=307, s=-5
    run_op("d100_10",   16'd100,   16'd10, Q_100_10,  1'b0, 14);
    // Ah=15 Bh=8 qm=480 s=7
    run_op("dffff_1",   16'hFFFF,  16'd1,  16'hF000,  1'b0, 14);
    run_op("d5_0",      16'd5,     16'd0,  16'hFFFF,  1'b1, 2);
    run_op("d0_9",      16'd0,     16'd9,  16'h0000,  1'b0, 2);
    run_op("d0_0",      16'd0,     16'd0,  16'hFFFF,  1'b1, 2);
    // Ah=12 Bh=14 qm=219 s=-9
    run_op("d3_7",      16'd3,     16'd7,  16'h0000,  1'b0, 14);
    // Ah=15 Bh=14 qm=274 s=-1, dropped bit 0
    run_op("d1000_7",   16'd1000,  16'd7,  16'd137,   1'b0, 14);
    // Ah=9 Bh=12 qm=192 s=6
    run_op("d40000_3",  16'd40000, 16'd3,  16'h3000,  1'b0, 14);
    // Ah=12 Bh=12 qm=256 s=-2
    run_op("d200_3",    16'd200,   16'd3,  16'd64,    1'b0, 14);

    // Back-pressure: result must hold while out_ready is low and new operands wait.
    a = 16'd100; b = 16'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd14);
    a = 16'hFFFF; b = 16'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_q",     32'(q),         32'(Q_100_10));
      check("bp_hold_dz",    32'(dz),        32'd0);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_idle_ready", 32'(in_ready),  32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_no_accept",  32'(in_ready),  32'd1);

    // Reset in the middle of the division.
    a = 16'd40000; b = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_q",     32'(q),         32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run_op("after_rst", 16'd1000, 16'd7, 16'd137, 1'b0, 14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loba_div_16_4.md
LOBA_DIV_16_4 -- requirements
Module: loba_div_16_4

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand and quotient width.
REQ-002 SHALL have parameter K, default 4, meaning the leading-one segment width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand pair.
REQ-007 SHALL have port a, input, N bits, the unsigned dividend.
REQ-008 SHALL have port b, input, N bits, the unsigned divisor.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning q and dz are valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 SHALL have port q, output, N bits, the approximate quotient.
REQ-012 SHALL have port dz, output, 1 bit, the divide-by-zero flag.

Function
REQ-013 SHALL accept operands on a rising edge with in_valid=1 and in_ready=1 (edge e0), registering a and b.
REQ-014 SHALL split each operand: ka is the leading-one position (0..N-1); Ah is the K bits from ka downward, zero-filled below bit 0 when ka<K-1; the same rule gives kb and Bh.
REQ-015 SHALL compute qm = floor((Ah<<2K)/Bh) by restoring division, one quotient bit per cycle, over 3K=12 cycles.
REQ-016 SHALL set the shift s = ka-kb-2K; q = qm<<s when s>=0, otherwise qm>>(-s) truncated, all results truncated to N bits.
REQ-017 SHALL implement FSM IDLE -> SPLIT (1 cycle) -> DIV (12 cycles) -> NORM (1 cycle) -> DONE.
REQ-018 SHALL assert out_valid after edge e14 for nonzero operands.
REQ-019 SHALL go from SPLIT directly to DONE when a==0 or b==0, with out_valid asserted after edge e2.
REQ-020 SHALL, for b==0, give q=all ones and dz=1; for a==0 and b!=0, give q=0 and dz=0; dz=0 in all other cases.
REQ-021 SHALL assert in_ready only in IDLE; new operands are not accepted while a result is in progress or pending.
REQ-022 SHALL hold q, dz and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL keep out_valid low and in_ready high in IDLE; in_ready is combinational from state only and does not depend on in_valid.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force state IDLE, in_ready=1, out_valid=0, q=0 and dz=0.
REQ-025 SHALL abandon any in-progress division on reset with no output produced; rst has priority over every handshake.

Configuration
REQ-026 SHALL round to nearest when macro LOBA_DIV_ROUND_EN is defined: when s<0, add the highest shifted-out bit of qm to the result, saturating at all ones.
REQ-027 SHALL truncate right shifts when LOBA_DIV_ROUND_EN is undefined; latency is the same in both builds.

Structure
REQ-028 SHALL place the FSM state enum and the constants N=16, K=4 and DIV_CYCLES=3K in package loba_div_pkg.
REQ-029 SHALL instantiate sub-module loba_lod twice, once per operand; loba_lod is a combinational leading-one detector and segment extractor that outputs the position and the K-bit segment.

Verification
REQ-030 SHALL check: a=100, b=10 -> ka=6, Ah=12, kb=3, Bh=10, qm=307, q=9 truncated (10 with LOBA_DIV_ROUND_EN), out_valid 14 cycles after acceptance.
REQ-031 SHALL check: a=0xFFFF, b=1 -> Ah=15, Bh=8, qm=480, s=7, q=0xF000, dz=0.
REQ-032 SHALL check: a=5, b=0 -> q=0xFFFF, dz=1, out_valid 2 cycles after acceptance; a=0, b=9 -> q=0, dz=0.
REQ-033 SHALL check: a=3, b=7 -> Ah=12, Bh=14, qm=219, s=-9, q=0 in both builds.
REQ-034 SHALL check back-pressure: out_ready held low 5 cycles -> q, dz and out_valid stable and in_ready=0; IDLE is re-entered on the edge where out_ready=1.
REQ-035 SHALL check reset mid-DIV (cycle 6): out_valid stays 0, in_ready=1 the next cycle, and the next operation gives the correct result.
